// File: rtl/priority_encoder_8to3_if.sv
// Request/code bundle between a requester/consumer and the sticky 8-to-3 priority encoder.
// master drives requests and ack; slave (the encoder) returns the registered code, valid and multi.
interface priority_encoder_8to3_if;
   logic [7:0] i;
   logic       en;
   logic       ack;
   logic [2:0] a;
   logic       valid;
   logic       multi;

   modport master (output i, en, ack, input a, valid, multi);
   modport slave  (input i, en, ack, output a, valid, multi);
endinterface

// File: rtl/priority_encoder_8to3.sv
// Sticky 8-to-3 priority encoder (i[7] wins); optional multi flag under ENC_MULTI_FLAG_EN.
// Latency: request in cycle N is presented from N+2; the code holds until ack, then one idle bubble.
module priority_encoder_8to3 (
   input  logic                        clk,
   input  logic                        rst_n,
   priority_encoder_8to3_if.slave      bus
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pend_q, pend_d;
   logic [7:0] clr;
   logic [2:0] a_q, a_d;
   logic [2:0] top_idx;
   logic       load;

   // Ascending scan so the highest set bit is the last one written.
   always_comb begin
      top_idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (pend_q[k]) top_idx = 3'(k);
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      clr     = 8'h00;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q != 8'h00) begin
               state_d = PRESENT;
               a_d     = top_idx;
               load    = 1'b1;
            end
         end
         PRESENT: begin
            if (bus.ack) begin
               state_d = IDLE;
               clr     = 8'b0000_0001 << a_q;
            end
         end
         default: state_d = IDLE;
      endcase
      // New capture is OR-ed after the clear so a same-edge re-request survives.
      pend_d = (pend_q & ~clr) | (bus.en ? bus.i : 8'h00);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= 8'h00;
         a_q     <= 3'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         a_q     <= a_d;
      end
   end

`ifdef ENC_MULTI_FLAG_EN
   logic [3:0] pop;
   logic       multi_q, multi_d;

   always_comb begin
      pop = 4'd0;
      for (int k = 0; k < 8; k++) begin
         pop = pop + {3'b000, pend_q[k]};
      end
      multi_d = load ? (pop > 4'd1) : multi_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) multi_q <= 1'b0;
      else        multi_q <= multi_d;
   end

   assign bus.multi = multi_q;
`else
   logic unused_load;
   assign unused_load = load;
   assign bus.multi   = 1'b0;
`endif

   assign bus.a     = a_q;
   assign bus.valid = (state_q == PRESENT);

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed bench for priority_encoder_8to3; expected codes are hand-derived from the request patterns.
module tb_priority_encoder_8to3;

   logic clk;
   logic rst_n;
   int   total;
   int   passed;

`ifdef ENC_MULTI_FLAG_EN
   localparam logic M = 1'b1;
`else
   localparam logic M = 1'b0;
`endif

   priority_encoder_8to3_if pif ();

   priority_encoder_8to3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (pif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [2:0] a, input logic m);
      chk({tag, ".valid"}, {7'd0, pif.valid}, {7'd0, v});
      chk({tag, ".a"},     {5'd0, pif.a},     {5'd0, a});
      chk({tag, ".multi"}, {7'd0, pif.multi}, {7'd0, m});
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack();
      pif.ack = 1'b1;
      cycle();
      pif.ack = 1'b0;
   endtask

   initial begin
      logic [2:0] seq_a [4];
      logic       seq_m [4];
      seq_a = '{3'd6, 3'd4, 3'd3, 3'd1};
      seq_m = '{M, M, M, 1'b0};
      total  = 0;
      passed = 0;
      rst_n  = 1'b1;
      pif.i   = 8'h00;
      pif.en  = 1'b0;
      pif.ack = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_out("reset", 1'b0, 3'd0, 1'b0);
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      chk_out("post_reset_idle", 1'b0, 3'd0, 1'b0);

      // Single pulse on i[3]
      pif.en = 1'b1; pif.i = 8'h08;
      cycle();
      pif.i = 8'h00;
      chk("pulse_N1.valid", {7'd0, pif.valid}, 8'd0);
      cycle();
      chk_out("pulse_N2", 1'b1, 3'd3, 1'b0);
      do_ack();
      chk("pulse_ack.valid", {7'd0, pif.valid}, 8'd0);
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("pulse_drained.valid", {7'd0, pif.valid}, 8'd0);
      end

      // Priority 8'h81
      pif.i = 8'h81;
      cycle();
      pif.i = 8'h00;
      cycle();
      chk_out("prio_first", 1'b1, 3'd7, M);
      do_ack();
      chk("prio_bubble.valid", {7'd0, pif.valid}, 8'd0);
      cycle();
      chk_out("prio_second", 1'b1, 3'd0, 1'b0);
      do_ack();
      cycle();
      chk("prio_idle.valid", {7'd0, pif.valid}, 8'd0);

      // Mixed pattern 8'h5A served 6,4,3,1
      pif.i = 8'h5A;
      cycle();
      pif.i = 8'h00;
      cycle();
      for (int s = 0; s < 4; s++) begin
         chk_out("mixed_load", 1'b1, seq_a[s], seq_m[s]);
         do_ack();
         chk("mixed_bubble.valid", {7'd0, pif.valid}, 8'd0);
         cycle();
      end
      chk("mixed_empty.valid", {7'd0, pif.valid}, 8'd0);

      // Hold: a=2 presented, higher request arrives while waiting
      pif.i = 8'h04;
      cycle();
      pif.i = 8'h00;
      cycle();
      for (int c = 0; c < 10; c++) begin
         pif.i = (c == 3) ? 8'h80 : 8'h00;
         cycle();
         chk_out("hold", 1'b1, 3'd2, 1'b0);
      end
      pif.i = 8'h00;
      do_ack();
      chk("hold_bubble.valid", {7'd0, pif.valid}, 8'd0);
      cycle();
      chk_out("hold_next", 1'b1, 3'd7, 1'b0);
      do_ack();
      cycle();

      // Set/clear collision on bit 4
      pif.i = 8'h10;
      cycle();
      pif.i = 8'h00;
      cycle();
      chk_out("coll_load", 1'b1, 3'd4, 1'b0);
      pif.ack = 1'b1; pif.i = 8'h10;
      cycle();
      pif.ack = 1'b0; pif.i = 8'h00;
      chk("coll_bubble.valid", {7'd0, pif.valid}, 8'd0);
      cycle();
      chk_out("coll_reload", 1'b1, 3'd4, 1'b0);
      do_ack();
      cycle();
      chk("coll_empty.valid", {7'd0, pif.valid}, 8'd0);

      // Enable gating and ack in IDLE
      pif.en = 1'b0; pif.i = 8'hFF;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("gated.valid", {7'd0, pif.valid}, 8'd0);
      end
      pif.i = 8'h00;
      do_ack();
      chk_out("idle_ack", 1'b0, 3'd4, 1'b0);
      cycle();
      chk("idle_ack_after.valid", {7'd0, pif.valid}, 8'd0);

      // Reset mid-PRESENT with a=5 and bit 0 still pending
      pif.en = 1'b1; pif.i = 8'h21;
      cycle();
      pif.i = 8'h00; pif.en = 1'b0;
      cycle();
      chk_out("pre_reset", 1'b1, 3'd5, M);
      #2 rst_n = 1'b0;
      #1 chk_out("async_reset", 1'b0, 3'd0, 1'b0);
      cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("after_reset.valid", {7'd0, pif.valid}, 8'd0);
      end
      pif.en = 1'b1; pif.i = 8'h02;
      cycle();
      pif.i = 8'h00;
      cycle();
      chk_out("after_reset_new", 1'b1, 3'd1, 1'b0);
      do_ack();
      cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
